// File: rtl/gem_trig_link_pkg.sv
// Shared constants, marker codes and lock-state type for the GEM trigger-link receiver.
package gem_trig_link_pkg;

   localparam logic [7:0] K_NORMAL  = 8'hBC;  // K28.5
   localparam logic [7:0] K_BC0     = 8'hF7;  // K23.7
   localparam logic [7:0] K_OVF     = 8'hFC;  // K28.7
   localparam logic [7:0] K_BC0_OVF = 8'hFB;  // K27.7

   localparam int unsigned FRAME_WORDS = 4;
   localparam int unsigned CLUSTER_W   = 14;
   localparam logic [CLUSTER_W-1:0] CLUSTER_INVALID = 14'h0600;

   typedef enum logic [1:0] {
      ST_HUNT,
      ST_VERIFY,
      ST_LOCKED
   } lock_state_t;

   function automatic logic is_marker(input logic [7:0] b);
      return b inside {K_NORMAL, K_BC0, K_OVF, K_BC0_OVF};
   endfunction

endpackage

// File: rtl/gem_trig_link_lock_fsm.sv
// Frame-alignment lock tracker: HUNT -> VERIFY -> LOCKED with good/bad frame counters.
module gem_trig_link_lock_fsm
   import gem_trig_link_pkg::*;
#(
   parameter int unsigned LOCK_FRAMES = 4,
   parameter int unsigned UNLOCK_ERRS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        frame_end,
   input  logic        frame_good,
   output lock_state_t state
);

   localparam int unsigned GW = $clog2(LOCK_FRAMES + 1);
   localparam int unsigned BW = $clog2(UNLOCK_ERRS + 1);

   lock_state_t   state_nxt;
   logic [GW-1:0] good_cnt, good_cnt_nxt;
   logic [BW-1:0] bad_cnt, bad_cnt_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_HUNT;
         good_cnt <= '0;
         bad_cnt  <= '0;
      end else begin
         state    <= state_nxt;
         good_cnt <= good_cnt_nxt;
         bad_cnt  <= bad_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      good_cnt_nxt = good_cnt;
      bad_cnt_nxt  = bad_cnt;
      unique case (state)
         ST_HUNT: begin
            if (start) begin
               state_nxt    = ST_VERIFY;
               good_cnt_nxt = '0;
            end
         end
         ST_VERIFY: begin
            if (frame_end) begin
               if (!frame_good) begin
                  state_nxt = ST_HUNT;
               end else if (good_cnt == GW'(LOCK_FRAMES - 1)) begin
                  state_nxt    = ST_LOCKED;
                  good_cnt_nxt = '0;
                  bad_cnt_nxt  = '0;
               end else begin
                  good_cnt_nxt = good_cnt + 1'b1;
               end
            end
         end
         ST_LOCKED: begin
            if (frame_end) begin
               if (frame_good) begin
                  bad_cnt_nxt = '0;
               end else if (bad_cnt == BW'(UNLOCK_ERRS - 1)) begin
                  state_nxt   = ST_HUNT;
                  bad_cnt_nxt = '0;
               end else begin
                  bad_cnt_nxt = bad_cnt + 1'b1;
               end
            end
         end
         default: state_nxt = ST_HUNT;
      endcase
   end

endmodule

// File: rtl/gem_trig_link_rx.sv
// Receive-side decoder for the 4-word OptoHybrid trigger-link frame: alignment,
// frame qualification, cluster/flag recovery, local BX counting and BC0 checking.
module gem_trig_link_rx
   import gem_trig_link_pkg::*;
#(
   parameter int unsigned LOCK_FRAMES  = 4,
   parameter int unsigned UNLOCK_ERRS  = 4,
   parameter int unsigned BX_PER_ORBIT = 3564
) (
   input  logic                 clk_160,
   input  logic                 reset,
   input  logic [15:0]          rx_data,
   input  logic [1:0]           rx_charisk,
   input  logic                 rx_code_err,
   output logic [CLUSTER_W-1:0] cluster0,
   output logic [CLUSTER_W-1:0] cluster1,
   output logic [CLUSTER_W-1:0] cluster2,
   output logic [CLUSTER_W-1:0] cluster3,
   output logic [3:0]           valid_clusters,
   output logic                 frame_valid,
   output logic                 bc0,
   output logic                 overflow,
   output logic [11:0]          bxn_counter,
   output logic                 locked,
   output logic                 bc0_err,
   output logic [15:0]          err_cnt
);

   localparam int unsigned PHASE_W = $clog2(FRAME_WORDS);
   localparam logic [11:0] BX_LAST = 12'(BX_PER_ORBIT - 1);

   lock_state_t        state;
   logic [PHASE_W-1:0] phase;
   logic               word0_ok, in_frame, start, frame_end, frame_good;
   logic               acc_ok, acc_bc0, acc_ovf;
   logic [39:0]        acc_data;
   logic [55:0]        frame_data;
   logic               bc0_seen;

   assign word0_ok   = (rx_charisk == 2'b01) && is_marker(rx_data[7:0]) && !rx_code_err;
   assign in_frame   = (state != ST_HUNT);
   assign start      = !in_frame && word0_ok;
   assign frame_end  = in_frame && (phase == PHASE_W'(FRAME_WORDS - 1));
   assign frame_good = frame_end && acc_ok && (rx_charisk == 2'b00) && !rx_code_err;
   assign frame_data = {rx_data, acc_data};
   assign locked     = (state == ST_LOCKED);

   gem_trig_link_lock_fsm #(
      .LOCK_FRAMES (LOCK_FRAMES),
      .UNLOCK_ERRS (UNLOCK_ERRS)
   ) u_lock_fsm (
      .clk        (clk_160),
      .reset      (reset),
      .start      (start),
      .frame_end  (frame_end),
      .frame_good (frame_good),
      .state      (state)
   );

   // Phase sits at 0 while hunting, so word0 is captured every cycle until a start is seen.
   always_ff @(posedge clk_160) begin
      if (reset) begin
         phase    <= '0;
         acc_ok   <= 1'b0;
         acc_bc0  <= 1'b0;
         acc_ovf  <= 1'b0;
         acc_data <= '0;
      end else begin
         if (in_frame)   phase <= phase + 1'b1;
         else if (start) phase <= PHASE_W'(1);
         else            phase <= '0;

         if (phase == PHASE_W'(0)) begin
            acc_ok         <= word0_ok;
            acc_bc0        <= (rx_data[7:0] == K_BC0) || (rx_data[7:0] == K_BC0_OVF);
            acc_ovf        <= (rx_data[7:0] == K_OVF) || (rx_data[7:0] == K_BC0_OVF);
            acc_data[7:0]  <= rx_data[15:8];
         end else if (phase == PHASE_W'(1)) begin
            acc_ok         <= acc_ok && (rx_charisk == 2'b00) && !rx_code_err;
            acc_data[23:8] <= rx_data;
         end else if (phase == PHASE_W'(2)) begin
            acc_ok          <= acc_ok && (rx_charisk == 2'b00) && !rx_code_err;
            acc_data[39:24] <= rx_data;
         end
      end
   end

   always_ff @(posedge clk_160) begin
      if (reset) begin
         cluster0    <= CLUSTER_INVALID;
         cluster1    <= CLUSTER_INVALID;
         cluster2    <= CLUSTER_INVALID;
         cluster3    <= CLUSTER_INVALID;
         frame_valid <= 1'b0;
         bc0         <= 1'b0;
         bc0_err     <= 1'b0;
         overflow    <= 1'b0;
         bxn_counter <= '0;
         err_cnt     <= '0;
         bc0_seen    <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         bc0         <= 1'b0;
         bc0_err     <= 1'b0;
         if (!locked) bc0_seen <= 1'b0;

         if (frame_end && !frame_good && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;

         if (frame_end && locked) begin
            if (frame_good) begin
               cluster0    <= frame_data[13:0];
               cluster1    <= frame_data[27:14];
               cluster2    <= frame_data[41:28];
               cluster3    <= frame_data[55:42];
               overflow    <= acc_ovf;
               frame_valid <= 1'b1;
               bc0         <= acc_bc0;
            end
            // A bad frame still occupies a BX slot, so the counter advances but never reloads.
            if (frame_good && acc_bc0) begin
               bxn_counter <= '0;
               bc0_seen    <= 1'b1;
               bc0_err     <= bc0_seen && (bxn_counter != BX_LAST);
            end else if (bxn_counter == BX_LAST) begin
               bxn_counter <= '0;
            end else begin
               bxn_counter <= bxn_counter + 1'b1;
            end
         end
      end
   end

   always_comb begin
      valid_clusters    = '0;
      valid_clusters[0] = ~(cluster0[10:9] == 2'b11);
      valid_clusters[1] = ~(cluster1[10:9] == 2'b11);
      valid_clusters[2] = ~(cluster2[10:9] == 2'b11);
      valid_clusters[3] = ~(cluster3[10:9] == 2'b11);
   end

endmodule

// File: tb/tb_gem_trig_link_rx.sv
// Bench for gem_trig_link_rx: frame-level reference model driven by directed and random streams.
module tb_gem_trig_link_rx;
   import gem_trig_link_pkg::*;

   localparam int BX      = 3564;
   localparam int LOCKN   = 4;
   localparam int UNLOCKN = 4;

   logic        clk_160 = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] rx_data = '0;
   logic [1:0]  rx_charisk = '0;
   logic        rx_code_err = 1'b0;
   logic [13:0] cluster0, cluster1, cluster2, cluster3;
   logic [3:0]  valid_clusters;
   logic        frame_valid, bc0, overflow, locked, bc0_err;
   logic [11:0] bxn_counter;
   logic [15:0] err_cnt;

   gem_trig_link_rx #(
      .LOCK_FRAMES  (LOCKN),
      .UNLOCK_ERRS  (UNLOCKN),
      .BX_PER_ORBIT (BX)
   ) dut (
      .clk_160        (clk_160),
      .reset          (reset),
      .rx_data        (rx_data),
      .rx_charisk     (rx_charisk),
      .rx_code_err    (rx_code_err),
      .cluster0       (cluster0),
      .cluster1       (cluster1),
      .cluster2       (cluster2),
      .cluster3       (cluster3),
      .valid_clusters (valid_clusters),
      .frame_valid    (frame_valid),
      .bc0            (bc0),
      .overflow       (overflow),
      .bxn_counter    (bxn_counter),
      .locked         (locked),
      .bc0_err        (bc0_err),
      .err_cnt        (err_cnt)
   );

   always #3 clk_160 = ~clk_160;

   int checks = 0;
   int errors = 0;

   // Frame-level reference model: 0 = hunting, 1 = verifying, 2 = locked
   int          m_state, m_good, m_bad, m_err, m_bxn;
   bit          m_seen, m_ovf;
   logic [13:0] m_cl [4];
   bit          e_fv, e_bc0, e_bc0err;
   int          m_fv_total = 0, m_bc0err_total = 0;

   bit o_fv, o_bc0, o_bc0err;
   int dut_fv_total = 0, dut_bc0err_total = 0, stray = 0;

   function automatic bit mk_valid(input logic [7:0] m);
      return (m == 8'hBC) || (m == 8'hF7) || (m == 8'hFC) || (m == 8'hFB);
   endfunction

   function automatic logic [55:0] rand_data();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[55:0];
   endfunction

   function automatic logic [29:0] exp_status();
      return {(m_state == 2), 16'(m_err), 12'(m_bxn), m_ovf};
   endfunction

   function automatic logic [59:0] exp_clusters();
      logic [3:0] vc;
      for (int n = 0; n < 4; n++) vc[n] = !(m_cl[n][10:9] == 2'b11);
      return {m_cl[3], m_cl[2], m_cl[1], m_cl[0], vc};
   endfunction

   task automatic model_reset();
      m_state = 0; m_good = 0; m_bad = 0; m_err = 0; m_bxn = 0;
      m_seen = 0; m_ovf = 0;
      for (int n = 0; n < 4; n++) m_cl[n] = 14'h0600;
      e_fv = 0; e_bc0 = 0; e_bc0err = 0;
   endtask

   task automatic model_frame(input logic [7:0] mk, input logic [55:0] d,
                              input logic [3:0] em, input logic [3:0] kf);
      bit good, w0ok, isbc0;
      good  = mk_valid(mk) && (em == 0) && (kf == 0);
      w0ok  = mk_valid(mk) && !em[0] && !kf[0];
      isbc0 = (mk == 8'hF7) || (mk == 8'hFB);
      e_fv = 0; e_bc0 = 0; e_bc0err = 0;
      if (m_state == 0) begin
         if (!w0ok) return;
         m_state = 1;
         m_good  = 0;
      end
      if (!good && m_err < 65535) m_err++;
      if (m_state == 1) begin
         if (good) begin
            m_good++;
            if (m_good == LOCKN) begin m_state = 2; m_bad = 0; end
         end else m_state = 0;
      end else if (good) begin
         m_bad = 0;
         e_fv  = 1;
         for (int n = 0; n < 4; n++) m_cl[n] = d[14*n +: 14];
         m_ovf = (mk == 8'hFC) || (mk == 8'hFB);
         if (isbc0) begin
            e_bc0    = 1;
            e_bc0err = m_seen && (m_bxn != BX - 1);
            m_seen   = 1;
            m_bxn    = 0;
         end else m_bxn = (m_bxn + 1) % BX;
      end else begin
         m_bxn = (m_bxn + 1) % BX;
         m_bad++;
         if (m_bad == UNLOCKN) begin m_state = 0; m_seen = 0; m_bad = 0; end
      end
      m_fv_total     += int'(e_fv);
      m_bc0err_total += int'(e_bc0err);
   endtask

   // Drives one 4-word frame back-to-back, then samples the strobes one cycle after word3.
   task automatic send_frame(input logic [7:0] mk, input logic [55:0] d,
                             input logic [3:0] em, input logic [3:0] kf);
      logic [15:0] w [4];
      w[0] = {d[7:0], mk}; w[1] = d[23:8]; w[2] = d[39:24]; w[3] = d[55:40];
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_160);
         if (i > 0 && (frame_valid || bc0 || bc0_err)) stray++;
         rx_data     = w[i];
         rx_charisk  = (i == 0) ? (kf[0] ? 2'b00 : 2'b01) : (kf[i] ? 2'b01 : 2'b00);
         rx_code_err = em[i];
      end
      @(posedge clk_160);
      #1;
      o_fv = frame_valid; o_bc0 = bc0; o_bc0err = bc0_err;
      dut_fv_total     += int'(o_fv);
      dut_bc0err_total += int'(o_bc0err);
      model_frame(mk, d, em, kf);
   endtask

   task automatic test_reset();
      @(negedge clk_160);
      reset = 1'b1; rx_data = '0; rx_charisk = '0; rx_code_err = 1'b0;
      repeat (3) @(negedge clk_160);
      model_reset();
      checks++;
      if ({locked, err_cnt, bxn_counter, overflow} !== exp_status()) begin
         errors++; $display("FAIL reset_status: got %h want %h", {locked, err_cnt, bxn_counter, overflow}, exp_status());
      end
      checks++;
      if ({cluster3, cluster2, cluster1, cluster0, valid_clusters} !== exp_clusters()) begin
         errors++; $display("FAIL reset_clusters: got %h want %h", {cluster3, cluster2, cluster1, cluster0, valid_clusters}, exp_clusters());
      end
      checks++;
      if ({frame_valid, bc0, bc0_err} !== 3'b000) begin
         errors++; $display("FAIL reset_strobes: got %b want 000", {frame_valid, bc0, bc0_err});
      end
      reset = 1'b0;
   endtask

   task automatic test_lock();
      for (int k = 0; k < 4; k++) begin
         send_frame(8'hBC, 56'h0, 4'h0, 4'h0);
         checks++;
         if ({locked, o_fv} !== {(k == 3), 1'b0}) begin
            errors++; $display("FAIL lock_frame%0d: got locked/fv %b want %b", k, {locked, o_fv}, {(k == 3), 1'b0});
         end
      end
   endtask

   task automatic test_first_frame();
      send_frame(8'hBC, {14'h0600, 14'h0600, 14'h0600, 14'h0005}, 4'h0, 4'h0);
      checks++;
      if ({o_fv, cluster0, valid_clusters, overflow} !== {1'b1, 14'h0005, 4'b0001, 1'b0}) begin
         errors++; $display("FAIL first_frame: got fv=%b c0=%h vc=%b ovf=%b want 1 0005 0001 0", o_fv, cluster0, valid_clusters, overflow);
      end
      checks++;
      if ({cluster3, cluster2, cluster1, cluster0, valid_clusters} !== exp_clusters()) begin
         errors++; $display("FAIL first_frame_model: got %h want %h", {cluster3, cluster2, cluster1, cluster0, valid_clusters}, exp_clusters());
      end
   endtask

   task automatic test_bc0_orbit();
      send_frame(8'hF7, rand_data(), 4'h0, 4'h0);
      checks++;
      if ({o_bc0, o_bc0err, bxn_counter} !== {2'b10, 12'd0}) begin
         errors++; $display("FAIL bc0_first: got bc0=%b err=%b bxn=%0d want 1 0 0", o_bc0, o_bc0err, bxn_counter);
      end
      for (int i = 0; i < BX - 1; i++) send_frame(8'hBC, rand_data(), 4'h0, 4'h0);
      checks++;
      if (bxn_counter !== 12'(BX - 1)) begin
         errors++; $display("FAIL bxn_orbit_end: got %0d want %0d", bxn_counter, BX - 1);
      end
      send_frame(8'hF7, rand_data(), 4'h0, 4'h0);
      checks++;
      if ({o_bc0, o_bc0err, bxn_counter} !== {2'b10, 12'd0}) begin
         errors++; $display("FAIL bc0_on_time: got bc0=%b err=%b bxn=%0d want 1 0 0", o_bc0, o_bc0err, bxn_counter);
      end
      checks++;
      if (dut_bc0err_total !== 0) begin
         errors++; $display("FAIL bc0_err_count_orbit: got %0d want 0", dut_bc0err_total);
      end
   endtask

   task automatic test_bc0_early();
      for (int i = 0; i < BX - 2; i++) send_frame(8'hBC, rand_data(), 4'h0, 4'h0);
      send_frame(8'hF7, rand_data(), 4'h0, 4'h0);
      checks++;
      if ({o_bc0, o_bc0err, bxn_counter} !== {2'b11, 12'd0}) begin
         errors++; $display("FAIL bc0_early: got bc0=%b err=%b bxn=%0d want 1 1 0", o_bc0, o_bc0err, bxn_counter);
      end
      send_frame(8'hBC, rand_data(), 4'h0, 4'h0);
      checks++;
      if ({o_bc0err, 32'(dut_bc0err_total)} !== {1'b0, 32'd1}) begin
         errors++; $display("FAIL bc0_err_once: got pulse=%b total=%0d want 0 1", o_bc0err, dut_bc0err_total);
      end
   endtask

   task automatic test_bc0_ovf();
      send_frame(8'hFB, rand_data(), 4'h0, 4'h0);
      checks++;
      if ({o_fv, o_bc0, overflow} !== 3'b111) begin
         errors++; $display("FAIL bc0_ovf: got fv/bc0/ovf %b want 111", {o_fv, o_bc0, overflow});
      end
      send_frame(8'hFC, rand_data(), 4'h0, 4'h0);
      checks++;
      if ({o_bc0, overflow} !== 2'b01) begin
         errors++; $display("FAIL ovf_only: got bc0/ovf %b want 01", {o_bc0, overflow});
      end
      send_frame(8'hBC, rand_data(), 4'h0, 4'h0);
      checks++;
      if ({locked, err_cnt, bxn_counter, overflow} !== exp_status()) begin
         errors++; $display("FAIL ovf_clear_status: got %h want %h", {locked, err_cnt, bxn_counter, overflow}, exp_status());
      end
   endtask

   task automatic test_code_err();
      logic [55:0] held;
      held = {cluster3, cluster2, cluster1, cluster0};
      for (int k = 0; k < 3; k++) begin
         send_frame(8'hBC, rand_data(), 4'b0100, 4'h0);
         checks++;
         if ({o_fv, locked, cluster3, cluster2, cluster1, cluster0} !== {2'b01, held}) begin
            errors++; $display("FAIL code_err_hold%0d: got fv=%b lk=%b cl=%h want 0 1 %h", k, o_fv, locked, {cluster3, cluster2, cluster1, cluster0}, held);
         end
      end
      send_frame(8'hBC, rand_data(), 4'h0, 4'h0);
      checks++;
      if ({o_fv, locked, err_cnt} !== {2'b11, 16'd3}) begin
         errors++; $display("FAIL code_err_recover: got fv=%b lk=%b err=%0d want 1 1 3", o_fv, locked, err_cnt);
      end
      for (int k = 0; k < 4; k++) begin
         send_frame(8'hBC, rand_data(), 4'b0100, 4'h0);
         checks++;
         if (locked !== (k < 3)) begin
            errors++; $display("FAIL unlock%0d: got locked=%b want %b", k, locked, (k < 3));
         end
      end
      checks++;
      if ({dut.u_lock_fsm.state == ST_HUNT, err_cnt} !== {1'b1, 16'd7}) begin
         errors++; $display("FAIL unlock_state: got hunt=%b err=%0d want 1 7", dut.u_lock_fsm.state == ST_HUNT, err_cnt);
      end
      for (int k = 0; k < 4; k++) send_frame(8'hBC, rand_data(), 4'h0, 4'h0);
      checks++;
      if ({locked, err_cnt, bxn_counter, overflow} !== exp_status()) begin
         errors++; $display("FAIL relock_status: got %h want %h", {locked, err_cnt, bxn_counter, overflow}, exp_status());
      end
   endtask

   task automatic test_misaligned_reset();
      logic [55:0] d;
      @(negedge clk_160);
      reset = 1'b1; rx_data = '0; rx_charisk = '0; rx_code_err = 1'b0;
      repeat (2) @(negedge clk_160);
      reset = 1'b0;
      model_reset();
      d = rand_data();
      @(negedge clk_160); rx_data = d[39:24]; rx_charisk = 2'b00;
      @(negedge clk_160); rx_data = d[55:40]; rx_charisk = 2'b00;
      send_frame(8'hBC, rand_data(), 4'h0, 4'h0);
      send_frame(8'hBC, rand_data(), 4'h0, 4'h0);
      d = rand_data();
      @(negedge clk_160); rx_data = {d[7:0], 8'hBC}; rx_charisk = 2'b01;
      @(negedge clk_160); rx_data = d[23:8]; rx_charisk = 2'b00;
      @(negedge clk_160); reset = 1'b1; rx_data = d[39:24];
      @(negedge clk_160); rx_data = d[55:40];
      @(negedge clk_160); reset = 1'b0; rx_data = '0;
      model_reset();
      checks++;
      if ({frame_valid, locked, err_cnt} !== 18'd0) begin
         errors++; $display("FAIL mid_reset: got fv=%b lk=%b err=%0d want 0 0 0", frame_valid, locked, err_cnt);
      end
      for (int k = 0; k < 4; k++) begin
         send_frame(8'hBC, rand_data(), 4'h0, 4'h0);
         checks++;
         if ({o_fv, locked, err_cnt} !== {1'b0, (k == 3), 16'd0}) begin
            errors++; $display("FAIL relock%0d: got fv=%b lk=%b err=%0d want 0 %b 0", k, o_fv, locked, err_cnt, (k == 3));
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] mk;
      logic [3:0] em, kf;
      int r;
      for (int f = 0; f < 400; f++) begin
         r  = $urandom_range(0, 9);
         mk = (r == 0) ? 8'hF7 : (r == 1) ? 8'hFC : (r == 2) ? 8'hFB : 8'hBC;
         em = 4'h0; kf = 4'h0;
         if (m_state != 0 && $urandom_range(0, 4) == 0) begin
            case ($urandom_range(0, 3))
               0: em[$urandom_range(0, 3)] = 1'b1;
               1: mk = 8'h1C;
               2: kf[$urandom_range(1, 3)] = 1'b1;
               default: kf[0] = 1'b1;
            endcase
         end
         send_frame(mk, rand_data(), em, kf);
         checks++;
         if ({locked, err_cnt, bxn_counter, overflow} !== exp_status()) begin
            errors++; $display("FAIL rand_status f%0d: got %h want %h", f, {locked, err_cnt, bxn_counter, overflow}, exp_status());
         end
         checks++;
         if ({cluster3, cluster2, cluster1, cluster0, valid_clusters} !== exp_clusters()) begin
            errors++; $display("FAIL rand_clusters f%0d: got %h want %h", f, {cluster3, cluster2, cluster1, cluster0, valid_clusters}, exp_clusters());
         end
         checks++;
         if ({o_fv, o_bc0, o_bc0err} !== {e_fv, e_bc0, e_bc0err}) begin
            errors++; $display("FAIL rand_strobes f%0d: got %b want %b", f, {o_fv, o_bc0, o_bc0err}, {e_fv, e_bc0, e_bc0err});
         end
      end
      checks++;
      if ({32'(stray), 32'(dut_fv_total), 32'(dut_bc0err_total)} !== {32'd0, 32'(m_fv_total), 32'(m_bc0err_total)}) begin
         errors++; $display("FAIL strobe_totals: got stray=%0d fv=%0d bc0err=%0d want 0 %0d %0d", stray, dut_fv_total, dut_bc0err_total, m_fv_total, m_bc0err_total);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_lock();
      test_first_frame();
      test_bc0_orbit();
      test_bc0_early();
      test_bc0_ovf();
      test_code_err();
      test_misaligned_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation still running at %0t", $time);
      $fatal(1);
   end

endmodule
